// File: rtl/divrem_unit.sv
// divrem_unit -- iterative integer divide / remainder unit for the EX stage.
//
// Executes DIV, DIVU, REM and REMU with a restoring divider that resolves
// BITS_PER_CYCLE quotient bits per clock. Divide-by-zero and signed overflow
// skip the iteration and finish one cycle after the start.
//
// Ports:
//   iCLK     pipeline clock
//   iRST     synchronous active-high reset
//   iStart   DivRem instruction present in EX (level, held while stalled)
//   iFlush   abort the current operation
//   iOp      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   iA, iB   dividend / divisor
//   oResult  quotient or remainder (registered, held until next completion)
//   oReady   single-cycle completion pulse
//   oBusy    iteration in progress
module divrem_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iFlush,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oResult,
  output logic             oReady,
  output logic             oBusy
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0]    STEPS_C = CW'(STEPS);
  localparam logic [CW-1:0]    ONE_C   = CW'(1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       stateReg;
  logic [CW-1:0]    cntReg;
  logic [WIDTH-1:0] quoReg;      // dividend bits shift out MSB-first, quotient bits shift in at LSB
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] divisorReg;
  logic             selRemReg;
  logic             negQReg;
  logic             negRReg;
  logic [WIDTH-1:0] resultReg;
  logic [WIDTH-1:0] prevResultReg; // restored if the completing cycle is flushed

  // Operand decode while IDLE
  logic             isSigned;
  logic             negA;
  logic             negB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             divZero;
  logic             overflow;
  logic [WIDTH-1:0] specialRes;

  assign isSigned   = ~iOp[0];
  assign negA       = isSigned & iA[WIDTH-1];
  assign negB       = isSigned & iB[WIDTH-1];
  assign magA       = negA ? -iA : iA;
  assign magB       = negB ? -iB : iB;
  assign divZero    = (iB == '0);
  assign overflow   = isSigned & (iA == MIN_VAL) & (iB == '1);
  assign specialRes = iOp[1] ? (divZero ? iA : '0)
                             : (divZero ? '1 : MIN_VAL);

  // One restoring step per generated stage; the stages chain combinationally
  // so a single clock resolves BITS_PER_CYCLE quotient bits.
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : gStep
    logic [WIDTH-1:0] remIn;
    logic [WIDTH-1:0] quoIn;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             keep;
    logic [WIDTH-1:0] remOut;
    logic [WIDTH-1:0] quoOut;

    if (gi == 0) begin : gFirst
      assign remIn = remReg;
      assign quoIn = quoReg;
    end else begin : gNext
      assign remIn = gStep[gi-1].remOut;
      assign quoIn = gStep[gi-1].quoOut;
    end

    assign partial = {remIn, quoIn[WIDTH-1]};
    assign keep    = (partial >= {1'b0, divisorReg});
    // When keep is set the difference is below the divisor, so WIDTH bits hold it.
    assign diff    = partial[WIDTH-1:0] - divisorReg;
    assign remOut  = keep ? diff : partial[WIDTH-1:0];
    assign quoOut  = {quoIn[WIDTH-2:0], keep};
  end

  logic [WIDTH-1:0] finalQ;
  logic [WIDTH-1:0] finalR;
  logic [WIDTH-1:0] calcRes;

  assign finalQ  = gStep[BITS_PER_CYCLE-1].quoOut;
  assign finalR  = gStep[BITS_PER_CYCLE-1].remOut;
  assign calcRes = selRemReg ? (negRReg ? -finalR : finalR)
                             : (negQReg ? -finalQ : finalQ);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateReg      <= IDLE;
      cntReg        <= '0;
      quoReg        <= '0;
      remReg        <= '0;
      divisorReg    <= '0;
      selRemReg     <= 1'b0;
      negQReg       <= 1'b0;
      negRReg       <= 1'b0;
      resultReg     <= '0;
      prevResultReg <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (iStart && !iFlush) begin
            selRemReg  <= iOp[1];
            negQReg    <= negA ^ negB;
            negRReg    <= negA;
            quoReg     <= magA;
            divisorReg <= magB;
            remReg     <= '0;
            cntReg     <= STEPS_C;
            if (divZero || overflow) begin
              prevResultReg <= resultReg;
              resultReg     <= specialRes;
              stateReg      <= DONE;
            end else begin
              stateReg <= CALC;
            end
          end
        end
        CALC: begin
          if (iFlush) begin
            stateReg <= IDLE;
          end else begin
            remReg <= finalR;
            quoReg <= finalQ;
            cntReg <= cntReg - ONE_C;
            if (cntReg == ONE_C) begin
              // Result is registered on the last iteration so it is stable in DONE.
              prevResultReg <= resultReg;
              resultReg     <= calcRes;
              stateReg      <= DONE;
            end
          end
        end
        DONE: begin
          stateReg <= IDLE;
          if (iFlush) begin
            resultReg <= prevResultReg;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign oReady  = (stateReg == DONE) & ~iFlush;
  assign oBusy   = (stateReg == CALC);
  assign oResult = resultReg;

endmodule

// File: tb/tb_divrem_unit.sv
// Testbench for divrem_unit: directed cases on the 1-bit-per-cycle build plus
// a randomized sweep over 1, 2 and 4 bits per cycle against a plain-arithmetic
// reference model.
module tb_divrem_unit;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iStart;
  logic        iFlush;
  logic [1:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;

  logic [31:0] res1, res2, res4;
  logic        rdy1, rdy2, rdy4;
  logic        busy1, busy2, busy4;

  always #5 iCLK = ~iCLK;

  divrem_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u1 (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFlush(iFlush), .iOp(iOp),
    .iA(iA), .iB(iB), .oResult(res1), .oReady(rdy1), .oBusy(busy1));
  divrem_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) u2 (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFlush(iFlush), .iOp(iOp),
    .iA(iA), .iB(iB), .oResult(res2), .oReady(rdy2), .oBusy(busy2));
  divrem_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u4 (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFlush(iFlush), .iOp(iOp),
    .iA(iA), .iB(iB), .oResult(res4), .oReady(rdy4), .oBusy(busy4));

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  int errCount = 0;
  int chkCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V division semantics with ordinary integer arithmetic.
  function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      q = -1;
      r = longint'($signed(a));
    end else if (op[0] == 1'b0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;            // truncates toward zero
      r = sa % sb;            // takes the sign of the dividend
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      q = sa / sb;
      r = sa % sb;
    end
    refModel = op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit isSpecial(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    isSpecial = (b == 32'd0) ||
                (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Called just before the start edge; returns at the negedge of the DONE cycle.
  task automatic waitReady1(output int lat, output logic [31:0] res);
    lat = -1;
    res = 'x;
    @(posedge iCLK);
    for (int k = 1; k <= 60; k++) begin
      @(negedge iCLK);
      if (rdy1) begin
        lat = k;
        res = res1;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes,
                       input int expLat, input bit hold);
    int lat;
    logic [31:0] res;
    @(negedge iCLK);
    iOp = op; iA = a; iB = b; iStart = 1'b1;
    waitReady1(lat, res);
    checkVal({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkVal({tag, "_res"}, res, expRes);
    $display("op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d (%s)", op, a, b, res, lat, tag);
    if (!hold) iStart = 1'b0;
  endtask

  initial begin
    int lat;
    int readyCnt;
    logic [31:0] res;

    iRST = 1'b1; iStart = 1'b0; iFlush = 1'b0; iOp = 2'b00; iA = '0; iB = '0;
    repeat (3) @(negedge iCLK);
    checkVal("reset_result", res1, 32'd0);
    checkVal("reset_ready", 32'(rdy1), 32'd0);
    checkVal("reset_busy", 32'(busy1), 32'd0);
    iRST = 1'b0;

    // Directed arithmetic
    runOp("div_100_7",   OP_DIV,  32'd100,       32'd7, 32'd14,        33, 0);
    runOp("rem_100_7",   OP_REM,  32'd100,       32'd7, 32'd2,         33, 0);
    runOp("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    runOp("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    runOp("remu_f9_2",   OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1,         33, 0);
    runOp("divu_ff_2",   OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, 0);
    runOp("div_by_zero", OP_DIV,  32'd5,         32'd0, 32'hFFFF_FFFF, 1,  0);
    runOp("rem_by_zero", OP_REM,  32'd5,         32'd0, 32'd5,         1,  0);
    runOp("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    runOp("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);

    // Back-to-back with iStart held high
    runOp("b2b_first", OP_DIV, 32'd100, 32'd7, 32'd14, 33, 1);
    iOp = OP_DIVU; iA = 32'd50; iB = 32'd5;
    @(posedge iCLK);
    @(negedge iCLK);
    checkVal("b2b_gap_busy", 32'(busy1), 32'd0);
    checkVal("b2b_gap_ready", 32'(rdy1), 32'd0);
    waitReady1(lat, res);
    checkVal("b2b_second_lat", 32'(lat), 32'd33);
    checkVal("b2b_second_res", res, 32'd10);
    $display("op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d (b2b_second)", iOp, iA, iB, res, lat);
    iStart = 1'b0;

    // Flush 10 cycles into CALC
    @(negedge iCLK);
    iOp = OP_DIV; iA = 32'd1000; iB = 32'd3; iStart = 1'b1;
    @(posedge iCLK);
    repeat (10) @(posedge iCLK);
    @(negedge iCLK);
    iFlush = 1'b1; iStart = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    iFlush = 1'b0;
    checkVal("flush_busy", 32'(busy1), 32'd0);
    checkVal("flush_ready", 32'(rdy1), 32'd0);
    checkVal("flush_keep_result", res1, 32'd10);
    readyCnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge iCLK);
      if (rdy1) readyCnt++;
    end
    checkVal("flush_no_ready", 32'(readyCnt), 32'd0);
    $display("flush mid-CALC: ready pulses afterwards=%0d result=0x%08h", readyCnt, res1);
    runOp("div_9_3_after_flush", OP_DIV, 32'd9, 32'd3, 32'd3, 33, 0);

    // Flush coinciding with DONE (divide by zero completes one cycle after start)
    @(negedge iCLK);
    iOp = OP_DIV; iA = 32'd5; iB = 32'd0; iStart = 1'b1;
    @(posedge iCLK);
    #1 iFlush = 1'b1; iStart = 1'b0;
    @(negedge iCLK);
    checkVal("flush_done_ready", 32'(rdy1), 32'd0);
    @(posedge iCLK);
    @(negedge iCLK);
    iFlush = 1'b0;
    checkVal("flush_done_keep_result", res1, 32'd3);
    $display("flush in DONE: result=0x%08h", res1);

    // Reset mid-CALC
    @(negedge iCLK);
    iOp = OP_DIV; iA = 32'd100; iB = 32'd7; iStart = 1'b1;
    @(posedge iCLK);
    repeat (5) @(posedge iCLK);
    @(negedge iCLK);
    checkVal("pre_reset_busy", 32'(busy1), 32'd1);
    iRST = 1'b1; iStart = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    checkVal("midreset_result", res1, 32'd0);
    checkVal("midreset_ready", 32'(rdy1), 32'd0);
    checkVal("midreset_busy", 32'(busy1), 32'd0);
    $display("reset mid-CALC: result=0x%08h busy=%0b ready=%0b", res1, busy1, rdy1);

    // Synchronise all three builds before the sweep
    @(negedge iCLK);
    iRST = 1'b0;

    // Randomized sweep; iStart is pulsed for one cycle only, so the operation
    // must also complete when iStart drops during CALC.
    for (int n = 0; n < 30; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b, exp;
      int          sel;
      int          lats[3];
      logic [31:0] ress[3];
      int          expLats[3];
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: b = 32'($urandom_range(1, 15));
        4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      exp = refModel(op, a, b);
      expLats[0] = isSpecial(op, a, b) ? 1 : 33;
      expLats[1] = isSpecial(op, a, b) ? 1 : 17;
      expLats[2] = isSpecial(op, a, b) ? 1 : 9;
      for (int d = 0; d < 3; d++) begin
        lats[d] = -1;
        ress[d] = 'x;
      end

      @(negedge iCLK);
      iOp = op; iA = a; iB = b; iStart = 1'b1;
      @(posedge iCLK);
      #1 iStart = 1'b0;
      for (int k = 1; k <= 60; k++) begin
        @(negedge iCLK);
        if (rdy1 && lats[0] < 0) begin lats[0] = k; ress[0] = res1; end
        if (rdy2 && lats[1] < 0) begin lats[1] = k; ress[1] = res2; end
        if (rdy4 && lats[2] < 0) begin lats[2] = k; ress[2] = res4; end
        if (lats[0] > 0 && lats[1] > 0 && lats[2] > 0) break;
      end
      checkVal("rnd_bpc1_res", ress[0], exp);
      checkVal("rnd_bpc2_res", ress[1], exp);
      checkVal("rnd_bpc4_res", ress[2], exp);
      checkVal("rnd_bpc1_lat", 32'(lats[0]), 32'(expLats[0]));
      checkVal("rnd_bpc2_lat", 32'(lats[1]), 32'(expLats[1]));
      checkVal("rnd_bpc4_lat", 32'(lats[2]), 32'(expLats[2]));
      $display("rnd op=%0d a=0x%08h b=0x%08h exp=0x%08h got=0x%08h/0x%08h/0x%08h lat=%0d/%0d/%0d",
               op, a, b, exp, ress[0], ress[1], ress[2], lats[0], lats[1], lats[2]);
    end

    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

endmodule
